// File: rtl/alu_fu_arbiter.sv
// Round-robin arbiter that shares one in-order ALU functional unit among
// NUM_REQ requesters. Issue goes through a valid/ready handshake. An in-order
// tag FIFO records each winner so every FU result returns to its issuer.

// Per-requester grant/response decode: compares this lane's ID with the
// current grant and with the tag at the FIFO head.
module alu_fu_arbiter_lane #(
  parameter int IW = 1,
  parameter int ID = 0
) (
  input  logic [IW-1:0] sel_i,
  input  logic [IW-1:0] head_i,
  input  logic          push_i,
  input  logic          rsp_vld_i,
  output logic          req_ready_o,
  output logic          rsp_valid_o
);
  assign req_ready_o = push_i    && (sel_i  == IW'(ID));
  assign rsp_valid_o = rsp_vld_i && (head_i == IW'(ID));
endmodule

module alu_fu_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][OP_W-1:0]    req_op,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
  output logic                            fu_valid,
  input  logic                            fu_ready,
  output logic [OP_W-1:0]                 fu_op,
  output logic [DATA_W-1:0]               fu_a,
  output logic [DATA_W-1:0]               fu_b,
  input  logic                            fu_rsp_valid,
  output logic                            fu_rsp_ready,
  input  logic [DATA_W-1:0]               fu_rsp_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [DATA_W-1:0]               rsp_data,
  output logic                            busy,
  output logic                            err_orphan
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int PW = TW + 1;

  typedef enum logic {ARB, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   wr_q, rd_q;
  logic [IW-1:0]   tag_q [TAG_DEPTH];
  logic            err_q;

  logic [PW-1:0]   count;
  logic            full, empty, push, pop, found;
  logic [IW-1:0]   sel, head;

  // Extra pointer bit separates full from empty when the indices match.
  assign count = wr_q - rd_q;
  assign full  = (count == PW'(TAG_DEPTH));
  assign empty = (wr_q == rd_q);
  assign head  = tag_q[rd_q[TW-1:0]];

  // Arbitration FSM: pick a winner in ARB, stay locked on it in HOLD.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_d     = rr_q;
    sel      = '0;
    fu_valid = 1'b0;
    push     = 1'b0;
    found    = 1'b0;
    case (state_q)
      ARB: begin
        if (!full) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
              found = 1'b1;
              sel   = IW'((int'(rr_q) + i) % NUM_REQ);
            end
          end
          if (found) begin
            fu_valid = 1'b1;
            if (fu_ready) begin
              push = 1'b1;
            end else begin
              state_d = HOLD;
              win_d   = sel;
            end
          end
        end
      end
      HOLD: begin
        sel = win_q;
        if (req_valid[win_q]) begin
          fu_valid = 1'b1;
          if (fu_ready) begin
            push    = 1'b1;
            state_d = ARB;
          end
        end else begin
          // Requester withdrew mid-handshake: abandon without issuing.
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (push) rr_d = IW'((int'(sel) + 1) % NUM_REQ);
  end

  // Operand mux is quiet (zero) whenever nothing is offered to the FU.
  always_comb begin
    fu_op = '0;
    fu_a  = '0;
    fu_b  = '0;
    if (fu_valid) begin
      fu_op = req_op[sel];
      fu_a  = req_a[sel];
      fu_b  = req_b[sel];
    end
  end

  // With no tags outstanding any response is an orphan; sink it.
  assign fu_rsp_ready = empty ? 1'b1 : rsp_ready[head];
  assign pop          = fu_rsp_valid && fu_rsp_ready && !empty;
  assign rsp_data     = fu_rsp_data;
  assign busy         = !empty || fu_valid;
  assign err_orphan   = err_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    alu_fu_arbiter_lane #(.IW(IW), .ID(g)) u_lane (
      .sel_i       (sel),
      .head_i      (head),
      .push_i      (push),
      .rsp_vld_i   (fu_rsp_valid && !empty),
      .req_ready_o (req_ready[g]),
      .rsp_valid_o (rsp_valid[g])
    );
  end

  // FSM state, latched winner and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      win_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
    end
  end

  // Tag FIFO: winner IDs in issue order, pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      if (push) begin
        tag_q[wr_q[TW-1:0]] <= sel;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  // Sticky orphan flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     err_q <= 1'b0;
    else if (fu_rsp_valid && empty) err_q <= 1'b1;
  end
endmodule
